fetch_unit: RTL and testbench

- Instruction-fetch front end. Acts as the requester for the synchronous instruction memory, which takes `PC`/`read_en` and returns `inst` one `pclk` edge later.
- Generates sequential word addresses and tracks in-flight reads.
- Buffers returned instructions and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects by killing in-flight and buffered fetches.

---
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end with in-flight tracking, output FIFO and redirect flush.
// Optional FETCH_HALT_ON_ZERO_EN: a captured all-zero word halts fetch until redirect or reset.
module fetch_unit #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] PC,
    output logic              read_en,
    input  logic [31:0]       inst,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic              halted
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, npc_q, npc_d;
    logic              rd_q, rd_d;
    logic              v1_q, v1_d, v2_q, v2_d;
    logic [ADDR_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic [31:0]       fifo_inst_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [AW-1:0]     wp_q, rp_q;
    logic [AW:0]       cnt_q;
    logic [AW+1:0]     occ;
    logic              issue, push, pop, zero_hit;

`ifdef FETCH_HALT_ON_ZERO_EN
    assign zero_hit = v2_q && (inst == 32'h0);
    assign halted   = (state_q == HALT);
`else
    assign zero_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    assign if_valid = (cnt_q != '0);
    assign if_inst  = if_valid ? fifo_inst_q[rp_q] : '0;
    assign if_pc    = if_valid ? fifo_pc_q[rp_q] : '0;
    assign PC       = pc_q;
    assign read_en  = rd_q;

    // Credits count buffered plus in-flight words, so a capture always finds room.
    always_comb begin
        occ     = (AW+2)'(cnt_q) + (AW+2)'(v1_q) + (AW+2)'(v2_q);
        issue   = (state_q == RUN) && (occ < (AW+2)'(FIFO_DEPTH)) && !zero_hit;
        push    = v2_q && !zero_hit && !redirect_valid;
        pop     = if_valid && if_ready && !redirect_valid;
        state_d = redirect_valid     ? (fetch_en ? RUN : IDLE) :
                  zero_hit           ? HALT :
                  (state_q == HALT)  ? HALT :
                  fetch_en           ? RUN : IDLE;
        rd_d    = redirect_valid ? fetch_en : issue;
        pc_d    = redirect_valid ? redirect_pc : issue ? npc_q : pc_q;
        npc_d   = redirect_valid ? redirect_pc + ADDR_W'(fetch_en) :
                  issue          ? npc_q + 1'b1 : npc_q;
        v1_d    = rd_d;
        p1_d    = pc_d;
        v2_d    = v1_q && !redirect_valid && !zero_hit;
        p2_d    = p1_q;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            npc_q   <= RESET_PC;
            rd_q    <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            p1_q    <= '0;
            p2_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            rd_q    <= rd_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_inst_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else if (redirect_valid) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_inst_q[wp_q] <= inst;
                fifo_pc_q[wp_q]   <= p2_q;
                wp_q              <= wp_q + 1'b1;
            end
            if (pop)
                rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench; expected stream is consecutive word addresses restarting at each redirect.
module tb_fetch_unit;
    logic        pclk = 0, rst_n = 1, fetch_en = 0, redirect_valid = 0, if_ready = 0;
    logic [7:0]  redirect_pc = 0, PC, if_pc;
    logic        read_en, if_valid, halted;
    logic [31:0] inst = 0, if_inst;
    logic [31:0] mem [256];
    int          total = 0, bad = 0;

    fetch_unit #(.ADDR_W(8), .RESET_PC(8'd0), .FIFO_DEPTH(4)) dut (
        .pclk(pclk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .PC(PC), .read_en(read_en), .inst(inst),
        .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc), .halted(halted)
    );

    always #5 pclk = ~pclk;

    // Synchronous instruction memory: returns 0 when not enabled.
    always @(posedge pclk) inst <= read_en ? mem[PC] : 32'h0;

    task automatic step;
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset;
        @(posedge pclk);
        #1;
        rst_n = 0; fetch_en = 0; if_ready = 0; redirect_valid = 0;
        step();
        rst_n = 1;
    endtask

    task automatic test_reset;
        #1 rst_n = 0;
        #1;
        total++; if (PC !== 8'd0) begin bad++; $display("FAIL reset_PC got=%0h want=0", PC); end
        total++; if (read_en !== 1'b0) begin bad++; $display("FAIL reset_read_en got=%0b want=0", read_en); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_if_valid got=%0b want=0", if_valid); end
        total++; if (if_inst !== 32'h0 || if_pc !== 8'h0) begin bad++; $display("FAIL reset_if_data got=%0h/%0h want=0/0", if_inst, if_pc); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0b want=0", halted); end
        step();
        rst_n = 1;
    endtask

    task automatic test_stream;
        logic [7:0] exp = 0;
        bit started = 0;
        do_reset();
        fetch_en = 1; if_ready = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge pclk);
            if (if_valid) begin
                started = 1;
                total++;
                if (if_pc !== exp || if_inst !== mem[exp]) begin bad++; $display("FAIL stream got=%0h/%0h want=%0h/%0h", if_pc, if_inst, exp, mem[exp]); end
                if (exp == 8'd0) begin total++; if (if_inst !== 32'h002081B3) begin bad++; $display("FAIL stream_inst0 got=%0h want=002081b3", if_inst); end end
                if (exp == 8'd1) begin total++; if (if_inst !== 32'h402081B3) begin bad++; $display("FAIL stream_inst1 got=%0h want=402081b3", if_inst); end end
                exp++;
            end else if (started) begin
                total++; bad++; $display("FAIL stream_gap got=0 want=1 at pc %0h", exp);
            end
        end
        total++; if (exp < 8'd30) begin bad++; $display("FAIL stream_count got=%0d want>=30", exp); end
    endtask

    task automatic test_stall;
        int issues = 0, seen = 0;
        logic [7:0] exp = 0;
        do_reset();
        fetch_en = 1; if_ready = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge pclk);
            if (read_en) issues++;
            if (if_valid) begin
                seen++;
                total++;
                if (if_pc !== 8'd0 || if_inst !== mem[0]) begin bad++; $display("FAIL stall_hold got=%0h/%0h want=0/%0h", if_pc, if_inst, mem[0]); end
            end
        end
        total++; if (issues != 4) begin bad++; $display("FAIL stall_issues got=%0d want=4", issues); end
        total++; if (read_en !== 1'b0) begin bad++; $display("FAIL stall_read_en got=%0b want=0", read_en); end
        total++; if (seen < 8) begin bad++; $display("FAIL stall_valid_cycles got=%0d want>=8", seen); end
        if_ready = 1;
        for (int c = 0; c < 20; c++) begin
            if (if_valid) begin
                total++;
                if (if_pc !== exp || if_inst !== mem[exp]) begin bad++; $display("FAIL stall_release got=%0h want=%0h", if_pc, exp); end
                exp++;
            end
            @(negedge pclk);
        end
        total++; if (exp < 8'd15) begin bad++; $display("FAIL stall_release_count got=%0d want>=15", exp); end
    endtask

    task automatic test_redirect;
        logic [7:0] exp = 0;
        int rc = -1, first_post = -1, post = 0;
        do_reset();
        fetch_en = 1; if_ready = 1;
        for (int c = 0; c < 30; c++) begin
            @(negedge pclk);
            if (rc < 0 && if_valid && if_pc == 8'd3) begin
                redirect_valid = 1; redirect_pc = 8'd8; rc = c; exp = 8'd8;
            end else if (if_valid) begin
                total++;
                if (if_pc !== exp || if_inst !== mem[exp]) begin bad++; $display("FAIL redirect_seq got=%0h want=%0h", if_pc, exp); end
                if (rc >= 0) begin post++; if (first_post < 0) first_post = c; end
                exp++;
            end
            step();
            redirect_valid = 0;
        end
        total++; if (rc < 0 || post < 3) begin bad++; $display("FAIL redirect_post got=%0d want>=3", post); end
        total++; if (first_post != rc + 3) begin bad++; $display("FAIL redirect_latency got=%0d want=%0d", first_post - rc, 3); end
    endtask

    task automatic test_wrap;
        logic [7:0] exp = 8'd254;
        int n = 0;
        do_reset();
        fetch_en = 1; if_ready = 1;
        redirect_valid = 1; redirect_pc = 8'd254;
        step();
        redirect_valid = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge pclk);
            if (if_valid) begin
                total++;
                if (if_pc !== exp || if_inst !== mem[exp]) begin bad++; $display("FAIL wrap got=%0h want=%0h", if_pc, exp); end
                exp++; n++;
            end
        end
        total++; if (n < 4) begin bad++; $display("FAIL wrap_count got=%0d want>=4", n); end
    endtask

    task automatic test_random;
        logic [7:0] exp = 0, held_pc = 0;
        logic [31:0] held_inst = 0;
        bit held = 0;
        int n = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            fetch_en       = ($urandom % 8) != 0;
            if_ready       = ($urandom % 3) != 0;
            redirect_valid = ($urandom % 25) == 0;
            redirect_pc    = 8'($urandom);
            @(negedge pclk);
            if (held) begin
                total++;
                if (!if_valid || if_pc !== held_pc || if_inst !== held_inst) begin bad++; $display("FAIL random_hold got=%0b/%0h want=1/%0h", if_valid, if_pc, held_pc); end
            end
`ifndef FETCH_HALT_ON_ZERO_EN
            total++; if (halted !== 1'b0) begin bad++; $display("FAIL random_halted got=%0b want=0", halted); end
`endif
            if (redirect_valid) exp = redirect_pc;
            else if (if_valid && if_ready) begin
                total++;
                if (if_pc !== exp || if_inst !== mem[exp]) begin bad++; $display("FAIL random_seq got=%0h/%0h want=%0h/%0h", if_pc, if_inst, exp, mem[exp]); end
                exp++; n++;
            end
            held = if_valid && !if_ready && !redirect_valid;
            held_pc = if_pc; held_inst = if_inst;
            step();
        end
        redirect_valid = 0;
        total++; if (n < 50) begin bad++; $display("FAIL random_count got=%0d want>=50", n); end
    endtask

    task automatic test_async_reset;
        logic [7:0] exp = 0;
        int n = 0;
        do_reset();
        fetch_en = 1; if_ready = 1;
        repeat (8) step();
        @(negedge pclk);
        #2 rst_n = 0;
        #1;
        total++; if ({PC, read_en, if_valid, if_inst, if_pc, halted} !== '0) begin bad++; $display("FAIL async_reset got=%0h/%0b/%0b/%0h/%0h want=all zero", PC, read_en, if_valid, if_inst, if_pc); end
        @(posedge pclk);
        #2 rst_n = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge pclk);
            if (if_valid) begin
                total++;
                if (if_pc !== exp || if_inst !== mem[exp]) begin bad++; $display("FAIL async_restart got=%0h want=%0h", if_pc, exp); end
                exp++; n++;
            end
        end
        total++; if (n < 10) begin bad++; $display("FAIL async_restart_count got=%0d want>=10", n); end
    endtask

`ifdef FETCH_HALT_ON_ZERO_EN
    task automatic test_halt;
        logic [7:0] exp = 0;
        for (int i = 15; i < 256; i++) mem[i] = 32'h0;
        do_reset();
        fetch_en = 1; if_ready = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge pclk);
            if (if_valid) begin
                total++;
                if (if_pc !== exp || if_inst !== mem[exp]) begin bad++; $display("FAIL halt_seq got=%0h want=%0h", if_pc, exp); end
                exp++;
            end
        end
        total++; if (exp !== 8'd15) begin bad++; $display("FAIL halt_count got=%0d want=15", exp); end
        total++; if (halted !== 1'b1 || if_valid !== 1'b0) begin bad++; $display("FAIL halt_state got=%0b/%0b want=1/0", halted, if_valid); end
        step();
        redirect_valid = 1; redirect_pc = 8'd0;
        step();
        redirect_valid = 0;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_exit got=%0b want=0", halted); end
        exp = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge pclk);
            if (if_valid) begin
                total++;
                if (if_pc !== exp) begin bad++; $display("FAIL halt_restart got=%0h want=%0h", if_pc, exp); end
                exp++;
            end
        end
        total++; if (exp < 8'd5) begin bad++; $display("FAIL halt_restart_count got=%0d want>=5", exp); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom | 32'h1;
        mem[0] = 32'h002081B3;
        mem[1] = 32'h402081B3;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_random();
        test_async_reset();
`ifdef FETCH_HALT_ON_ZERO_EN
        test_halt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
